// File: rtl/program_counter.sv
// Instruction-fetch program counter with Start/Done run handshake and a
// saturating RUN-cycle counter; absolute branches resolve through the branch-target LUT.
//
// state | meaning
// IDLE  | out of reset, waiting for Start
// RUN   | fetching; PC advances, branches or stalls each edge
// DONE  | HALT retired; PC and CycleCount frozen until the next Start
module program_counter #(
  parameter int PC_W   = 10,
  parameter int TGT_W  = 8,
  parameter int LUT_AW = 3,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Stall,
  input  logic              Halt,
  input  logic              BranchEn,
  input  logic              Taken,
  input  logic              BranchRel,
  input  logic [TGT_W-1:0]  Offset,
  input  logic [LUT_AW-1:0] BranchIdx,
  output logic [LUT_AW-1:0] LutAddr,
  input  logic [TGT_W-1:0]  LutTarget,
  output logic [PC_W-1:0]   PC,
  output logic              Running,
  output logic              Done,
  output logic [CNT_W-1:0]  CycleCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [PC_W-1:0]  PC_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state_q, state_nxt;
  logic [PC_W-1:0]   pc_q, pc_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [PC_W-1:0]   lut_pc;
  logic [PC_W-1:0]   off_pc;

  // Resize LUT target (zero-extend) and Offset (sign-extend) to PC width;
  // when PC is narrower both are truncated, which keeps the add modulo 2^PC_W.
  generate
    if (PC_W > TGT_W) begin : g_wide
      assign lut_pc = {{(PC_W-TGT_W){1'b0}}, LutTarget};
      assign off_pc = {{(PC_W-TGT_W){Offset[TGT_W-1]}}, Offset};
    end else if (PC_W == TGT_W) begin : g_equal
      assign lut_pc = LutTarget;
      assign off_pc = Offset;
    end else begin : g_narrow
      assign lut_pc = LutTarget[PC_W-1:0];
      assign off_pc = Offset[PC_W-1:0];
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      pc_q    <= pc_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    pc_nxt    = pc_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          state_nxt = RUN;
          pc_nxt    = '0;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        // Every RUN edge counts, stalled and Halt edges included.
        if (cnt_q != CNT_MAX) cnt_nxt = cnt_q + CNT_ONE;
        if (Stall) begin
          pc_nxt = pc_q;
        end else if (Halt) begin
          state_nxt = DONE;
        end else if (BranchEn && Taken && !BranchRel) begin
          pc_nxt = lut_pc;
        end else if (BranchEn && Taken && BranchRel) begin
          pc_nxt = pc_q + off_pc;
        end else begin
          pc_nxt = pc_q + PC_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        pc_nxt    = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign LutAddr    = BranchIdx;
  assign PC         = pc_q;
  assign Running    = (state_q == RUN);
  assign Done       = (state_q == DONE);
  assign CycleCount = cnt_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: default instance plus a CNT_W=4 instance
// sharing the same stimulus to exercise counter saturation.
module tb_program_counter;

  logic        Clk = 1'b0;
  logic        Reset, Start, Stall, Halt, BranchEn, Taken, BranchRel;
  logic [7:0]  Offset, LutTarget;
  logic [2:0]  BranchIdx;
  logic [2:0]  LutAddr, LutAddr4;
  logic [9:0]  PC, PC4;
  logic        Running, Done, Running4, Done4;
  logic [15:0] CycleCount;
  logic [3:0]  CycleCount4;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  program_counter u_dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .Halt(Halt),
    .BranchEn(BranchEn), .Taken(Taken), .BranchRel(BranchRel), .Offset(Offset),
    .BranchIdx(BranchIdx), .LutAddr(LutAddr), .LutTarget(LutTarget), .PC(PC),
    .Running(Running), .Done(Done), .CycleCount(CycleCount)
  );

  program_counter #(.CNT_W(4)) u_dut4 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .Halt(Halt),
    .BranchEn(BranchEn), .Taken(Taken), .BranchRel(BranchRel), .Offset(Offset),
    .BranchIdx(BranchIdx), .LutAddr(LutAddr4), .LutTarget(LutTarget), .PC(PC4),
    .Running(Running4), .Done(Done4), .CycleCount(CycleCount4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Advance one edge; inputs change #1 after the edge and are checked there.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr();
    Start = 0; Stall = 0; Halt = 0; BranchEn = 0; Taken = 0; BranchRel = 0;
    Offset = 8'h00; LutTarget = 8'h00; BranchIdx = 3'd0;
  endtask

  task automatic abs_br(input logic [7:0] tgt);
    BranchEn = 1; Taken = 1; BranchRel = 0; LutTarget = tgt;
    step();
    clr();
  endtask

  task automatic rel_br(input logic [7:0] off);
    BranchEn = 1; Taken = 1; BranchRel = 1; Offset = off;
    step();
    clr();
  endtask

  initial begin
    clr();
    Reset = 1;
    step(); step();
    chk("rst_pc", PC, 10'd0);
    chk("rst_running", Running, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_cnt", CycleCount, 16'd0);
    Reset = 0;

    // 1: Start then 5 plain cycles
    Start = 1; step(); Start = 0;
    chk("t1_pc0", PC, 10'd0);
    chk("t1_running0", Running, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk($sformatf("t1_pc%0d", i), PC, i);
    end
    chk("t1_running", Running, 1'b1);
    chk("t1_cnt", CycleCount, 16'd5);
    chk("t1_cnt4", CycleCount4, 4'd5);

    // 2: absolute branch via LUT at PC=2
    Reset = 1; step(); Reset = 0;
    Start = 1; step(); Start = 0;          // cnt 0
    step(); step();                        // PC=2, cnt 2
    chk("t2_pc_pre", PC, 10'd2);
    BranchEn = 1; Taken = 1; BranchRel = 0; BranchIdx = 3'd3; LutTarget = 8'h05;
    #1;
    chk("t2_lutaddr", LutAddr, 3'd3);
    step(); clr();                         // cnt 3
    chk("t2_pc", PC, 10'd5);

    // 3: relative branches, including wrap below zero
    repeat (5) step();                     // PC=10, cnt 8
    chk("t3_pc_pre", PC, 10'd10);
    rel_br(8'hFC);                         // cnt 9
    chk("t3_rel", PC, 10'd6);
    abs_br(8'h01);                         // cnt 10
    chk("t3_abs1", PC, 10'd1);
    rel_br(8'hFC);                         // cnt 11
    chk("t3_wrap", PC, 10'h3FD);

    // 4: Stall wins over Halt, then Halt, then restart from DONE
    abs_br(8'h07);                         // cnt 12
    Stall = 1; Halt = 1; step(); clr();    // cnt 13
    chk("t4_stall_pc", PC, 10'd7);
    chk("t4_stall_running", Running, 1'b1);
    chk("t4_stall_cnt", CycleCount, 16'd13);
    Halt = 1; step(); clr();               // cnt 14
    chk("t4_done", Done, 1'b1);
    chk("t4_done_running", Running, 1'b0);
    chk("t4_done_pc", PC, 10'd7);
    chk("t4_done_cnt", CycleCount, 16'd14);
    BranchEn = 1; Taken = 1; LutTarget = 8'h22; step(); clr();
    chk("t4_hold_pc", PC, 10'd7);
    chk("t4_hold_cnt", CycleCount, 16'd14);
    chk("t4_hold_done", Done, 1'b1);
    Start = 1; step(); Start = 0;
    chk("t4_restart_pc", PC, 10'd0);
    chk("t4_restart_running", Running, 1'b1);
    chk("t4_restart_cnt", CycleCount, 16'd0);

    // 5: Start ignored in RUN, then Reset mid-run
    abs_br(8'h3F);
    Start = 1; step(); Start = 0;
    chk("t5_start_in_run_pc", PC, 10'h040);
    chk("t5_start_in_run_running", Running, 1'b1);
    Reset = 1; BranchEn = 1; Taken = 1; LutTarget = 8'h99; step(); clr();
    Reset = 0;
    chk("t5_rst_pc", PC, 10'd0);
    chk("t5_rst_running", Running, 1'b0);
    chk("t5_rst_done", Done, 1'b0);
    chk("t5_rst_cnt", CycleCount, 16'd0);
    Halt = 1; BranchEn = 1; Taken = 1; LutTarget = 8'h33; step(); clr();
    chk("t5_idle_pc", PC, 10'd0);
    chk("t5_idle_running", Running, 1'b0);
    chk("t5_idle_done", Done, 1'b0);

    // 6: not-taken branch, PC wrap at 0x3FF, counter saturation
    Start = 1; step(); Start = 0;
    BranchEn = 1; Taken = 0; BranchRel = 0; LutTarget = 8'h55; step(); clr();   // edge 1
    chk("t6_not_taken", PC, 10'd1);
    rel_br(8'hFE);                                                              // edge 2
    chk("t6_pc_3ff", PC, 10'h3FF);
    step();                                                                     // edge 3
    chk("t6_wrap0", PC, 10'd0);
    repeat (12) step();                                                         // edge 15
    chk("t6_cnt4_at15", CycleCount4, 4'd15);
    repeat (5) step();                                                          // edge 20
    chk("t6_pc_end", PC, 10'd17);
    chk("t6_cnt", CycleCount, 16'd20);
    chk("t6_cnt4_sat", CycleCount4, 4'd15);
    chk("t6_pc4", PC4, 10'd17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
